// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states,
// vector addresses, unmapped-read value and the RAM range test.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;
    localparam logic [7:0]  UNMAPPED_RD = 8'hFF;

    // RAM occupies 0 .. 2^aw-1; anything with bits set above that is outside.
    function automatic logic mem_in_ram(input logic [15:0] a, input int unsigned aw);
        return (a >> aw) == 16'h0000;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/acknowledge bus between a CPU core and mem_responder.
interface mem_responder_if;
    logic        req;
    logic [15:0] addr;
    logic        mem_rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        err;

    modport master (output req, addr, mem_rw, wdata, input rdata, ack, err);
    modport slave  (input req, addr, mem_rw, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_ram.sv
// Single-port synchronous byte RAM, read-first, with write enable; no reset on contents.
module mem_ram #(
    parameter int unsigned AWIDTH = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);
    logic [7:0] r_mem [0:(1 << AWIDTH) - 1];
    logic [7:0] r_dout;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_dout <= r_mem[i_addr];
    end

    assign o_rdata = r_dout;
endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: on-chip RAM, one output port register and the reset
// vector, served through a 3-state IDLE/WAIT/DONE handshake with optional wait states.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned RAM_AWIDTH  = 11,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hD000,
    parameter logic [15:0] RESET_VEC   = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus,
    output logic [7:0]      io_out
);
    state_t      r_state;
    logic [1:0]  r_wait_cnt;
    logic [15:0] r_addr;
    logic        r_rw;
    logic [7:0]  r_wdata;
    logic        r_ack;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic [7:0]  r_io;

    logic [15:0] w_dec_addr;
    logic        w_dec_rw;
    logic        w_bad_wr;
    logic        w_ram_we;
    logic [7:0]  w_ram_dout;
    logic [7:0]  w_rd_val;

    // In IDLE the live bus is decoded so a zero-wait access can enter DONE
    // with err and the RAM read already resolved; afterwards only latched values count.
    assign w_dec_addr = (r_state == IDLE) ? bus.addr   : r_addr;
    assign w_dec_rw   = (r_state == IDLE) ? bus.mem_rw : r_rw;
    assign w_bad_wr   = !w_dec_rw && (w_dec_addr != IO_ADDR) && !mem_in_ram(w_dec_addr, RAM_AWIDTH);
    assign w_ram_we   = (r_state == DONE) && !r_rw && (r_addr != IO_ADDR) && mem_in_ram(r_addr, RAM_AWIDTH);

    mem_ram #(
        .AWIDTH(RAM_AWIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_dec_addr[RAM_AWIDTH-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_dout)
    );

    always_comb begin
        w_rd_val = UNMAPPED_RD;
        if (r_addr == VEC_LO_ADDR) begin
            w_rd_val = RESET_VEC[7:0];
        end else if (r_addr == VEC_HI_ADDR) begin
            w_rd_val = RESET_VEC[15:8];
        end else if (r_addr == IO_ADDR) begin
            w_rd_val = r_io;
        end else if (mem_in_ram(r_addr, RAM_AWIDTH)) begin
            w_rd_val = w_ram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_wdata    <= '0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_io       <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_addr     <= bus.addr;
                        r_rw       <= bus.mem_rw;
                        r_wdata    <= bus.wdata;
                        r_wait_cnt <= 2'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            r_state <= DONE;
                            r_ack   <= 1'b1;
                            r_err   <= w_bad_wr;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 2'd1;
                    if (r_wait_cnt == 2'd1) begin
                        r_state <= DONE;
                        r_ack   <= 1'b1;
                        r_err   <= w_bad_wr;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    if (r_rw) begin
                        r_rdata <= w_rd_val;
                    end else if (r_addr == IO_ADDR) begin
                        r_io <= r_wdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // During DONE the read value comes straight from the flops/RAM output
    // register; it is captured into r_rdata so it holds until the next read.
    assign bus.rdata = (r_ack && r_rw) ? w_rd_val : r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign io_out    = r_io;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a one-wait-state instance for the access
// scenarios and a zero-wait instance for back-to-back streaming.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] io1;
    logic [7:0] io0;
    int n_total = 0;
    int n_bad = 0;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

    mem_responder #(
        .RAM_AWIDTH (11),
        .WAIT_STATES(1),
        .IO_ADDR    (16'hD000),
        .RESET_VEC  (16'hC000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .io_out(io1)
    );

    mem_responder #(
        .RAM_AWIDTH (11),
        .WAIT_STATES(0),
        .IO_ADDR    (16'hD000),
        .RESET_VEC  (16'hC000)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave),
        .io_out(io0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access on the one-wait-state instance, started from IDLE; returns to IDLE.
    task automatic acc(input logic rw, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic er, output int cyc,
                       output logic [7:0] io_at_ack);
        cyc = 0;
        bus.req    = 1'b1;
        bus.mem_rw = rw;
        bus.addr   = a;
        bus.wdata  = d;
        while (!bus.ack && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.ack) chk("ack_timeout", 32'd0, 32'd1);
        rd        = bus.rdata;
        er        = bus.err;
        io_at_ack = io1;
        bus.req   = 1'b0;
        bus.addr  = 16'h7777;
        bus.wdata = 8'hEE;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] ioa;
        logic er;
        int cyc;
        logic ack_seen;

        bus.req = 1'b0;  bus.addr = '0;  bus.mem_rw = 1'b1;  bus.wdata = '0;
        bus0.req = 1'b0; bus0.addr = '0; bus0.mem_rw = 1'b1; bus0.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'h00);
        chk("rst_io", 32'(io1), 32'h00);
        chk("rst_io0", 32'(io0), 32'h00);
        rst_n = 1'b1;

        // RAM write then read back with one wait state
        acc(1'b0, 16'h0010, 8'hA5, rd, er, cyc, ioa);
        chk("wr10_lat", 32'(cyc), 32'd2);
        chk("wr10_err", 32'(er), 32'd0);
        acc(1'b1, 16'h0010, 8'h00, rd, er, cyc, ioa);
        chk("rd10_lat", 32'(cyc), 32'd2);
        chk("rd10_data", 32'(rd), 32'hA5);
        chk("rd10_err", 32'(er), 32'd0);
        chk("rd10_hold", 32'(bus.rdata), 32'hA5);

        // reset vector bytes
        acc(1'b1, 16'hFFFC, 8'h00, rd, er, cyc, ioa);
        chk("vec_lo", 32'(rd), 32'h00);
        acc(1'b1, 16'hFFFD, 8'h00, rd, er, cyc, ioa);
        chk("vec_hi", 32'(rd), 32'hC0);

        // output port: old value during ack, new value the cycle after
        acc(1'b0, 16'hD000, 8'h3C, rd, er, cyc, ioa);
        chk("io_wr_err", 32'(er), 32'd0);
        chk("io_at_ack", 32'(ioa), 32'h00);
        chk("io_after", 32'(io1), 32'h3C);
        acc(1'b1, 16'hD000, 8'h00, rd, er, cyc, ioa);
        chk("io_rd", 32'(rd), 32'h3C);

        // illegal write outside RAM, no aliasing onto RAM[0]
        acc(1'b0, 16'h0000, 8'h11, rd, er, cyc, ioa);
        acc(1'b0, 16'h1000, 8'h55, rd, er, cyc, ioa);
        chk("bad_wr_err", 32'(er), 32'd1);
        chk("bad_wr_lat", 32'(cyc), 32'd2);
        chk("err_pulse", 32'(bus.err), 32'd0);
        acc(1'b1, 16'h1000, 8'h00, rd, er, cyc, ioa);
        chk("unmap_1000", 32'(rd), 32'hFF);
        chk("unmap_rd_err", 32'(er), 32'd0);
        acc(1'b1, 16'h0000, 8'h00, rd, er, cyc, ioa);
        chk("ram0_kept", 32'(rd), 32'h11);
        acc(1'b1, 16'h8000, 8'h00, rd, er, cyc, ioa);
        chk("unmap_8000", 32'(rd), 32'hFF);

        // a write leaves rdata at the last read value
        acc(1'b0, 16'h0030, 8'h22, rd, er, cyc, ioa);
        chk("wr_keeps_rdata", 32'(rd), 32'hFF);
        chk("wr_keeps_idle", 32'(bus.rdata), 32'hFF);

        // reset in WAIT aborts the write
        acc(1'b0, 16'h0020, 8'h99, rd, er, cyc, ioa);
        bus.req = 1'b1; bus.mem_rw = 1'b0; bus.addr = 16'h0020; bus.wdata = 8'h77;
        @(posedge clk);
        #1;
        chk("pre_abort_ack", 32'(bus.ack), 32'd0);
        rst_n = 1'b0;
        #1;
        bus.req = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            ack_seen = ack_seen | bus.ack;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            ack_seen = ack_seen | bus.ack;
        end
        chk("abort_no_ack", 32'(ack_seen), 32'd0);
        chk("abort_io_rst", 32'(io1), 32'h00);
        chk("abort_rdata_rst", 32'(bus.rdata), 32'h00);
        acc(1'b1, 16'h0020, 8'h00, rd, er, cyc, ioa);
        chk("abort_rd20", 32'(rd), 32'h99);
        chk("post_rst_lat", 32'(cyc), 32'd2);

        // zero wait states, req held: ack every second cycle
        bus0.req = 1'b1; bus0.mem_rw = 1'b0; bus0.addr = 16'h0040; bus0.wdata = 8'hE1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_ack%0d", k), 32'(bus0.ack), (k % 2 == 0 && k < 7) ? 32'd1 : 32'd0);
            case (k)
                0: begin
                    bus0.addr = 16'h0041; bus0.wdata = 8'hE2;
                end
                2: begin
                    bus0.mem_rw = 1'b1; bus0.addr = 16'h0040;
                end
                4: begin
                    chk("b2b_rd40", 32'(bus0.rdata), 32'hE1);
                    bus0.addr = 16'h0041;
                    #1;
                    chk("b2b_rd40_mid", 32'(bus0.rdata), 32'hE1);
                end
                6: begin
                    chk("b2b_rd41", 32'(bus0.rdata), 32'hE2);
                    bus0.req = 1'b0;
                end
                default: ;
            endcase
        end
        chk("b2b_hold", 32'(bus0.rdata), 32'hE2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
